// File: rtl/pipe_delay_pkg.sv
// Shared constants and types for the pipe_delay block.
package pipe_delay_pkg;

  localparam int unsigned DEPTH_MAX    = 16;
  localparam int unsigned DEF_CHANNELS = 4;
  localparam int unsigned DEF_WIDTH    = 12;
  localparam int unsigned DEF_DEPTH    = 4;

  typedef logic [4:0] tap_t;

  // Folds a requested tap into 1..depth: 0 selects the first stage, oversize selects the last.
  function automatic tap_t eff_tap(input tap_t sel, input tap_t depth);
    if (sel == '0)
      return tap_t'(1);
    else if (sel > depth)
      return depth;
    else
      return sel;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One register stage of the delay chain: data plus valid, with advance enable and flush.
module delay_stage #(
  parameter int unsigned W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Flush drops only the valid bit; the stale data is harmless once unqualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= src_valid;
      data  <= src_data;
    end
  end

endmodule

// File: rtl/pipe_delay.sv
// Multi-channel enable-gated delay line with valid tracking and fill count.
// Define DELAY_RUNTIME_SEL_EN to select the output tap at run time via dly_sel.
module pipe_delay
  import pipe_delay_pkg::*;
#(
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [4:0]                dly_sel,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [4:0]                fill_cnt
);

  localparam int unsigned W = CHANNELS * WIDTH;

  // Index 0 is the chain input; index k is the output of stage k-1 (tap k).
  logic [W-1:0] chain_data  [DEPTH+1];
  logic         chain_valid [DEPTH+1];

  assign chain_data[0]  = in_data;
  assign chain_valid[0] = in_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    delay_stage #(.W(W)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .flush     (flush),
      .src_valid (chain_valid[k]),
      .src_data  (chain_data[k]),
      .valid     (chain_valid[k+1]),
      .data      (chain_data[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
    end else if (flush) begin
      fill_cnt <= '0;
    end else if (en) begin
      case ({in_valid, chain_valid[DEPTH]})
        2'b10:   if (fill_cnt < tap_t'(DEPTH)) fill_cnt <= fill_cnt + 5'd1;
        2'b01:   if (fill_cnt != '0) fill_cnt <= fill_cnt - 5'd1;
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

`ifdef DELAY_RUNTIME_SEL_EN
  tap_t tap;

  assign tap = eff_tap(dly_sel, tap_t'(DEPTH));

  always_comb begin
    out_data  = chain_data[DEPTH];
    out_valid = chain_valid[DEPTH];
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (tap == tap_t'(k)) begin
        out_data  = chain_data[k];
        out_valid = chain_valid[k];
      end
    end
  end
`else
  logic unused_dly_sel;

  assign unused_dly_sel = ^dly_sel;
  assign out_data       = chain_data[DEPTH];
  assign out_valid      = chain_valid[DEPTH];
`endif

endmodule
